// File: rtl/vga_timing_ctrl.sv
// VGA timing master: horizontal/vertical counters, pixel request decode,
// registered sync/valid/frame-start outputs and the blanked rgb mux.
module vga_timing_ctrl #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_VALID  = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_VALID  = 480,
  parameter int V_FRONT  = 10,
  parameter int SYNC_POL = 0
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        en,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic        rgb_valid,
  output logic [15:0] rgb,
  output logic        frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HA_START = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] HA_END   = 10'(H_SYNC + H_BACK + H_VALID - 1);
  localparam logic [9:0] VA_START = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] VA_END   = 10'(V_SYNC + V_BACK + V_VALID - 1);
  localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
  localparam logic       SYNC_ON  = 1'(SYNC_POL);
  localparam logic       SYNC_OFF = ~SYNC_ON;
  localparam logic [9:0] PIX_IDLE = 10'h3FF;

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       rgb_valid_q, rgb_valid_d;
  logic       frame_start_q, frame_start_d;
  logic       h_act_s, v_act_s, active_s;

  // Counter advance; a dropped enable parks both counters at the frame origin.
  always_comb begin
    h_cnt_d = 10'd0;
    v_cnt_d = 10'd0;
    if (en) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = 10'd0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d = 10'd0;
        end else begin
          v_cnt_d = v_cnt_q + 10'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
      end
    end else begin
      h_cnt_d = 10'd0;
      v_cnt_d = 10'd0;
    end
  end

  // Active-region decode and pixel request coordinates.
  always_comb begin
    h_act_s  = (h_cnt_q >= HA_START) && (h_cnt_q <= HA_END);
    v_act_s  = (v_cnt_q >= VA_START) && (v_cnt_q <= VA_END);
    active_s = en && h_act_s && v_act_s;
    if (active_s) begin
      pix_x = h_cnt_q - HA_START;
      pix_y = v_cnt_q - VA_START;
    end else begin
      pix_x = PIX_IDLE;
      pix_y = PIX_IDLE;
    end
  end

  // Next values of the registered outputs, one cycle behind the counters so
  // they line up with the generator's registered pix_data.
  always_comb begin
    hsync_d       = SYNC_OFF;
    vsync_d       = SYNC_OFF;
    rgb_valid_d   = active_s;
    frame_start_d = 1'b0;
    if (en) begin
      hsync_d       = (h_cnt_q < H_SYNC_W) ? SYNC_ON : SYNC_OFF;
      vsync_d       = (v_cnt_q < V_SYNC_W) ? SYNC_ON : SYNC_OFF;
      frame_start_d = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    end else begin
      hsync_d       = SYNC_OFF;
      vsync_d       = SYNC_OFF;
      frame_start_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      hsync_q       <= SYNC_OFF;
      vsync_q       <= SYNC_OFF;
      rgb_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      rgb_valid_q   <= rgb_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign rgb_valid   = rgb_valid_q;
  assign frame_start = frame_start_q;
  assign rgb         = rgb_valid_q ? pix_data : 16'h0000;

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Timing master for the VGA output path and the other end of the pixel interface served by the colour-bar pattern generator.
- Runs the horizontal and vertical counters and drives pix_x/pix_y requests to the generator.
- Accepts the generator's registered pix_data one cycle later and produces hsync, vsync and the blanked rgb bus for the DAC/pins.
- Default timing is 640x480@60 Hz on a 25 MHz pixel clock.

Parameters:
- H_SYNC, 96, hsync pulse width in clocks.
- H_BACK, 48, horizontal back porch in clocks.
- H_VALID, 640, active pixels per line.
- H_FRONT, 16, horizontal front porch in clocks.
- V_SYNC, 2, vsync pulse width in lines.
- V_BACK, 33, vertical back porch in lines.
- V_VALID, 480, active lines per frame.
- V_FRONT, 10, vertical front porch in lines.
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low).

Ports:
- sys_clk  in  1  pixel clock.
- sys_rst  in  1  asynchronous active-high reset.
- en  in  1  timing enable, sampled synchronously.
- pix_data  in  16  RGB565 from pattern generator, registered one cycle after the pix_x/pix_y it answers.
- pix_x  out  10  requested column 0..H_VALID-1, 10'h3FF outside active.
- pix_y  out  10  requested row 0..V_VALID-1, 10'h3FF outside active.
- hsync  out  1  horizontal sync.
- vsync  out  1  vertical sync.
- rgb_valid  out  1  high while rgb carries an active pixel.
- rgb  out  16  pixel to display; 16'h0000 when blanked.
- frame_start  out  1  one-cycle pulse marking the first clock of each frame.

Behaviour:
- Derived constants:
  - H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
  - HA_START = H_SYNC+H_BACK (144); HA_END = HA_START+H_VALID-1 (783).
  - VA_START = V_SYNC+V_BACK (35); VA_END = VA_START+V_VALID-1 (514).
  - H_TOTAL and V_TOTAL must be ≤1024; counters are 10 bits.
- Counters:
  - h_cnt counts 0..H_TOTAL-1, +1 per clock while en=1, wrapping to 0 after H_TOTAL-1.
  - v_cnt increments when h_cnt==H_TOTAL-1 and wraps to 0 after V_TOTAL-1 on that same cycle.
- Enable:
  - While en=0, h_cnt and v_cnt are held at 0 and all registered outputs are driven idle.
  - On the first clock with en=1, count (0,0) is decoded; outputs reflect it on the following edge.
  - A mid-frame deassert of en aborts the frame; there is no completion of the current line.
- Active decode (combinational from the counters):
  - active = en & h_cnt∈[HA_START,HA_END] & v_cnt∈[VA_START,VA_END].
  - pix_x = active ? h_cnt-HA_START : 10'h3FF.
  - pix_y = active ? v_cnt-VA_START : 10'h3FF.
- Registered outputs (1-cycle latency from the counter value, aligned with the generator's pix_data latency):
  - hsync = SYNC_POL when en & h_cnt<H_SYNC, else ~SYNC_POL.
  - vsync = SYNC_POL when en & v_cnt<V_SYNC, else ~SYNC_POL.
  - rgb_valid = active.
  - frame_start = en & h_cnt==0 & v_cnt==0.
- rgb = rgb_valid ? pix_data : 16'h0000 (combinational mux, no further register).
- Reset (async assert, output change without a clock edge):
  - h_cnt=v_cnt=0.
  - hsync=vsync=~SYNC_POL; rgb_valid=0; frame_start=0.
  - Consequently pix_x=pix_y=10'h3FF and rgb=0.
  - Reset release is synchronous to sys_clk; counting starts at the first edge with sys_rst low and en high.
- Per frame: exactly H_VALID*V_VALID rgb_valid cycles and exactly one frame_start pulse.

Test Plan:
- Reset release, en=1: hsync low for exactly 96 consecutive cycles starting 1 clock after the first enabled edge; then high 704 cycles; period 800; vsync stays low for the first 1600 clocks.
- Full frame: vsync low 1600 clocks, period 420000 clocks; frame_start pulses once per 420000 clocks; rgb_valid high count = 307200.
- Active mapping:
  - (h_cnt,v_cnt)=(144,35) → pix_x=0, pix_y=0, rgb_valid=1 next cycle.
  - (783,514) → pix_x=639, pix_y=479.
  - (784,514) and (144,515) → both 10'h3FF.
- Blanking: pix_data tied 16'hF800 → rgb=F800 only on rgb_valid cycles, 0000 in all porch/sync cycles; with a model generator returning 16'h0000+pix_x, rgb equals the previous cycle's pix_x.
- en dropped at (400,100) → next edge: rgb_valid=0, hsync=vsync=1, pix_x=3FF; en raised → frame_start=1 one clock later, timing restarts from (0,0).
- sys_rst asserted mid-line between clock edges → hsync/vsync=1, rgb_valid=0, rgb=0, pix_x=3FF immediately; after release the frame restarts at (0,0).
